// File: rtl/tff_sched_pkg.sv
// ----------------------------------------------------------------------------
// tff_sched_pkg : shared types, default widths and round-robin pick function
//                 for the toggle-flop bank scheduler.
// Revision      : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package tff_sched_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam int NREQ_DEF     = 3;
   localparam int HOLD_CYC_DEF = 3;
   localparam int PTR_W        = $clog2(NREQ_DEF);
   localparam int CNT_W        = $clog2(HOLD_CYC_DEF + 1);

   // The pick function works on a fixed-size vector so any NREQ up to MAX_NREQ fits.
   localparam int MAX_NREQ = 32;
   localparam int IDX_W    = 5;

   typedef struct packed {
      logic             found;
      logic [IDX_W-1:0] idx;
   } rr_pick_t;

   function automatic rr_pick_t rr_pick(input logic [MAX_NREQ-1:0] valid,
                                        input int unsigned         ptr,
                                        input int unsigned         nreq);
      rr_pick_t    r;
      int unsigned j;
      r.found = 1'b0;
      r.idx   = '0;
      for (int unsigned k = 0; k < MAX_NREQ; k++) begin
         j = (ptr + k) % nreq;
         if (k < nreq && !r.found && valid[j]) begin
            r.found = 1'b1;
            r.idx   = j[IDX_W-1:0];
         end
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/tff_cell.sv
// ----------------------------------------------------------------------------
// tff_cell : single toggle flip-flop with synchronous active-high reset.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tff_cell (
   input  logic clk,
   input  logic rst,
   input  logic t,
   output logic q,
   output logic qbar
);

   logic r_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= 1'b0;
      end else if (t) begin
         r_q <= ~r_q;
      end
   end

   assign q    = r_q;
   assign qbar = ~r_q;

endmodule

`default_nettype wire

// File: rtl/tff_bank_sched.sv
// ----------------------------------------------------------------------------
// tff_bank_sched : round-robin scheduler sharing a bank of toggle flip-flops
//                  among requesters, with one-shot and timed-pulse modes.
// Revision       : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tff_bank_sched
   import tff_sched_pkg::*;
#(
   parameter  int WIDTH    = 4,
   parameter  int NREQ     = 3,
   parameter  int HOLD_CYC = 3,
   localparam int SEL_W    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ-1:0]       req_pulse,
   input  logic [NREQ*WIDTH-1:0] req_mask,
   output logic [NREQ-1:0]       req_ready,
   output logic [WIDTH-1:0]      q,
   output logic [WIDTH-1:0]      qbar,
   output logic [SEL_W-1:0]      grant_id,
   output logic                  busy,
   output logic                  done
);

   localparam int HCNT_W = $clog2(HOLD_CYC + 1);

   state_t              r_state, w_state_nxt;
   logic [HCNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [WIDTH-1:0]    r_saved, w_saved_nxt;
   logic                r_busy, w_busy_nxt;
   logic                r_done, w_done_nxt;
   logic [SEL_W-1:0]    r_ptr, w_ptr_nxt;
   logic [SEL_W-1:0]    r_gid, w_gid_nxt;

   rr_pick_t            w_pick;
   logic [SEL_W-1:0]    w_idx;
   logic                w_accept;
   logic                w_restore;
   logic                w_win_pulse;
   logic [WIDTH-1:0]    w_win_mask;
   logic [WIDTH-1:0]    w_t;
   logic [NREQ-1:0]     w_ready;

   assign w_pick    = rr_pick(MAX_NREQ'(req_valid), 32'(r_ptr), NREQ);
   assign w_idx     = w_pick.idx[SEL_W-1:0];
   // Reset wins over any accept, so ready is masked while rst is high.
   assign w_accept  = !rst && (r_state == IDLE) && w_pick.found;
   assign w_restore = (r_state == HOLD) && (r_cnt == '0);

   always_comb begin
      w_win_mask  = '0;
      w_win_pulse = 1'b0;
      w_ready     = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_idx == SEL_W'(i)) begin
            w_win_mask  = req_mask[i*WIDTH +: WIDTH];
            w_win_pulse = req_pulse[i];
            w_ready[i]  = w_accept;
         end
      end
   end

   assign w_t = w_accept ? w_win_mask : (w_restore ? r_saved : '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_saved <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_ptr   <= '0;
         r_gid   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_saved <= w_saved_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_ptr   <= w_ptr_nxt;
         r_gid   <= w_gid_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_saved_nxt = r_saved;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_ptr_nxt   = r_ptr;
      w_gid_nxt   = r_gid;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_gid_nxt = w_idx;
               w_ptr_nxt = (w_idx == SEL_W'(NREQ - 1)) ? '0 : w_idx + SEL_W'(1);
               if (w_win_pulse) begin
                  w_saved_nxt = w_win_mask;
                  w_cnt_nxt   = HCNT_W'(HOLD_CYC - 1);
                  w_busy_nxt  = 1'b1;
                  w_state_nxt = HOLD;
               end else begin
                  w_done_nxt  = 1'b1;
               end
            end
         end
         HOLD: begin
            if (w_restore) begin
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt   = r_cnt - HCNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_cell
      tff_cell u_cell (
         .clk  (clk),
         .rst  (rst),
         .t    (w_t[g]),
         .q    (q[g]),
         .qbar (qbar[g])
      );
   end

   assign req_ready = w_ready;
   assign grant_id  = r_gid;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

`default_nettype wire

// File: doc/tff_bank_sched.md
Name: tff_bank_sched

Overview:
- Round-robin scheduler that shares one bank of WIDTH toggle flip-flops among NREQ requesters.
- Each requester submits a toggle mask, either as a one-shot toggle or as a timed pulse (toggle, hold, toggle back).
- The block owns the bank state q/qbar.
- It sits between control agents (clock dividers, strobe generators) and the shared toggle-flop outputs.

Parameters:
- WIDTH, 4, number of toggle flip-flops in the bank (>=1).
- NREQ, 3, number of requesters (>=2).
- HOLD_CYC, 3, cycles a pulse-mode toggle stays applied before restore (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_pulse  in  NREQ  per-requester mode: 1 = pulse, 0 = one-shot toggle.
- req_mask  in  NREQ*WIDTH  per-requester toggle mask; requester i uses bits [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  one-hot-or-zero acceptance, combinational.
- q  out  WIDTH  bank state.
- qbar  out  WIDTH  bitwise ~q, combinational.
- grant_id  out  $clog2(NREQ)  index of last accepted requester, registered.
- busy  out  1  high while a pulse is holding.
- done  out  1  one-cycle pulse on operation completion.

Behaviour:
- Reset values: q=0, qbar=all ones, grant_id=0, busy=0, done=0, state=IDLE, rr_ptr=0, hold counter=0.
- States: IDLE and HOLD.
- Arbitration:
  - Only in IDLE. The winner is the first valid requester scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready[winner]=1; all other bits 0. In HOLD, req_ready=0.
  - Accept = req_valid[i] & req_ready[i].
  - On accept: rr_ptr <= (i+1) mod NREQ and grant_id <= i.
  - With no valid request, rr_ptr holds.
- Requesters hold valid, mask and pulse stable until accepted. Dropping valid before acceptance withdraws the request and is legal.
- One-shot accept, at edge E:
  - q <= q ^ mask and done <= 1, both visible after E.
  - State stays IDLE, so back-to-back accepts are possible every cycle.
- Pulse accept, at edge E:
  - q <= q ^ mask; saved_mask <= mask; cnt <= HOLD_CYC-1; busy <= 1; state <= HOLD.
- In HOLD, each edge:
  - If cnt==0: q <= q ^ saved_mask, busy <= 0, done <= 1, state <= IDLE.
  - Otherwise cnt <= cnt-1.
  - Net timing: the toggled value is visible for exactly HOLD_CYC cycles; done is high in the cycle after restore.
- done is 0 in every cycle not named above.
- Zero mask is accepted normally: q unchanged, done still pulses, and a pulse still occupies HOLD_CYC cycles.
- Overlapping mask bits across requests XOR-accumulate; the restore XORs only saved_mask.
- Reset mid-pulse: the restore is abandoned, q=0, and all reset values apply on the next cycle.
- Reset takes priority over any accept in the same cycle.
- qbar is always ~q, including during reset.
- The bank is built from WIDTH tff_cell instances: T = accept/restore strobe AND mask bit.

Decomposition:
- Package tff_sched_pkg:
  - state enum {IDLE, HOLD}.
  - Localparams PTR_W=$clog2(NREQ) and CNT_W=$clog2(HOLD_CYC+1).
  - A function that returns the round-robin winner index and a found flag, given valid and ptr.
- Sub-module tff_cell:
  - Single toggle flip-flop with synchronous active-high reset and t input; outputs q and qbar.
  - Instantiated WIDTH times in a generate loop.
- The scheduler module itself holds the arbiter, the FSM and the hold counter.

Test Plan:
- Reset check: assert rst for 2 cycles with all valids high → q=0000, qbar=1111, req_ready=000, done=0; after release, req_ready=001 if req_valid[0]=1.
- One-shot fairness: all three requesters valid continuously with masks 0001, 0010 and 0100, one-shot mode → grants in order 0,1,2,0 on consecutive cycles; q goes 0001, 0011, 0111, 0110; done high every cycle after the first accept.
- Pulse timing: requester 1 sends a pulse with mask 1010, HOLD_CYC=3, accepted at cycle 5 → q=1010 during cycles 6-8, q=0000 at cycle 9, done=1 at cycle 9 only, busy=1 during cycles 6-8, req_ready=000 during cycles 6-8.
- Blocking during pulse: requester 2 raises valid at cycle 6 during the above pulse → no accept until cycle 9; grant_id=2 after the cycle-9 edge.
- Reset mid-pulse: pulse with mask 1111 accepted, then rst asserted in its second HOLD cycle → q=0000, busy=0, done=0 with no restore pulse; rr_ptr=0.
- Zero mask and withdrawal: requester 0 sends a one-shot with mask 0000 → q unchanged, done=1. Requester 1 raises then drops valid while requester 2 wins → requester 1 never granted and rr_ptr advances only past 2.
